// File: rtl/ca_chip_sequencer.sv
// C/A chip sequencer: paces the C/A code generator at a programmable chip
// rate, samples its chip output once per chip, counts chips/epochs, pulls one
// navigation bit per bit period and emits the spread chip with a strobe.
module ca_chip_sequencer #(
   parameter int unsigned EPOCHS_PER_BIT  = 20,
   parameter int unsigned CHIPS_PER_EPOCH = 1023,
   parameter int unsigned DIV_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [DIV_W-1:0] clks_per_chip,
   input  logic             chip_in,
   output logic             code_enb,
   output logic             code_rst,
   input  logic             nav_valid,
   input  logic             nav_bit,
   output logic             nav_ready,
   output logic             spread_out,
   output logic             spread_valid,
   output logic [9:0]       chip_idx,
   output logic             epoch,
   output logic             bit_epoch,
   output logic             underrun,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALIGN,
      S_RUN
   } state_t;

   localparam logic [DIV_W-1:0] MIN_CPC = DIV_W'(3);
   localparam logic [9:0]       LAST_CHIP  = 10'(CHIPS_PER_EPOCH - 1);
   localparam logic [5:0]       LAST_EPOCH = 6'(EPOCHS_PER_BIT - 1);

   state_t           state_q;
   logic [1:0]       align_q;
   logic [DIV_W-1:0] cpc_q;
   logic [DIV_W-1:0] div_q;
   logic [9:0]       chip_cnt_q;
   logic [5:0]       epoch_cnt_q;
   logic             cur_bit_q;
   logic             code_enb_q;
   logic             code_rst_q;
   logic             nav_ready_q;
   logic             spread_out_q;
   logic             spread_valid_q;
   logic [9:0]       chip_idx_q;
   logic             epoch_q;
   logic             bit_epoch_q;
   logic             underrun_q;

   logic [DIV_W-1:0] cpc_d;
   logic [DIV_W-1:0] div_d;
   logic [9:0]       chip_cnt_d;
   logic [5:0]       epoch_cnt_d;
   logic             chip_cycle;
   logic             last_chip;
   logic             last_epoch;

   // Next-value helpers: clamped chip period, divider/counter wrap logic.
   always_comb begin
      cpc_d       = (clks_per_chip < MIN_CPC) ? MIN_CPC : clks_per_chip;
      div_d       = (div_q == cpc_q - DIV_W'(1)) ? '0 : div_q + DIV_W'(1);
      chip_cycle  = (state_q == S_RUN) && (div_q == '0);
      last_chip   = (chip_cnt_q == LAST_CHIP);
      last_epoch  = (epoch_cnt_q == LAST_EPOCH);
      chip_cnt_d  = last_chip ? '0 : chip_cnt_q + 10'd1;
      epoch_cnt_d = last_epoch ? '0 : epoch_cnt_q + 6'd1;
   end

   // Sequencer FSM with all outputs registered.
   // stop/start overrides sit after the case so a chip sampled in the same
   // cycle as a restart still emits its spread_valid, while stop wins over all.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         align_q        <= '0;
         cpc_q          <= MIN_CPC;
         div_q          <= '0;
         chip_cnt_q     <= '0;
         epoch_cnt_q    <= '0;
         cur_bit_q      <= 1'b0;
         code_enb_q     <= 1'b0;
         code_rst_q     <= 1'b0;
         nav_ready_q    <= 1'b0;
         spread_out_q   <= 1'b0;
         spread_valid_q <= 1'b0;
         chip_idx_q     <= '0;
         epoch_q        <= 1'b0;
         bit_epoch_q    <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         code_enb_q     <= 1'b0;
         code_rst_q     <= 1'b0;
         nav_ready_q    <= 1'b0;
         spread_valid_q <= 1'b0;
         epoch_q        <= 1'b0;
         bit_epoch_q    <= 1'b0;

         if (nav_ready_q) begin
            if (nav_valid) begin
               cur_bit_q <= nav_bit;
            end else begin
               cur_bit_q  <= 1'b0;
               underrun_q <= 1'b1;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (start && !stop) begin
                  cpc_q      <= cpc_d;
                  underrun_q <= 1'b0;
                  code_rst_q <= 1'b1;
                  align_q    <= '0;
                  state_q    <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (align_q == 2'd2) begin
                  state_q     <= S_RUN;
                  div_q       <= '0;
                  chip_cnt_q  <= '0;
                  epoch_cnt_q <= '0;
                  code_enb_q  <= 1'b1;
               end else begin
                  align_q <= align_q + 2'd1;
                  if (align_q == 2'd1) begin
                     nav_ready_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               div_q      <= div_d;
               code_enb_q <= (div_d == '0);
               if (chip_cycle) begin
                  spread_out_q   <= chip_in ^ cur_bit_q;
                  spread_valid_q <= 1'b1;
                  chip_idx_q     <= chip_cnt_q;
                  chip_cnt_q     <= chip_cnt_d;
                  epoch_q        <= last_chip;
                  if (last_chip) begin
                     epoch_cnt_q <= epoch_cnt_d;
                     if (last_epoch) begin
                        bit_epoch_q <= 1'b1;
                        nav_ready_q <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (stop && state_q != S_IDLE) begin
            state_q        <= S_IDLE;
            code_enb_q     <= 1'b0;
            code_rst_q     <= 1'b0;
            nav_ready_q    <= 1'b0;
            spread_valid_q <= 1'b0;
            epoch_q        <= 1'b0;
            bit_epoch_q    <= 1'b0;
         end else if (start && state_q != S_IDLE) begin
            cpc_q       <= cpc_d;
            underrun_q  <= 1'b0;
            code_rst_q  <= 1'b1;
            code_enb_q  <= 1'b0;
            nav_ready_q <= 1'b0;
            align_q     <= '0;
            state_q     <= S_ALIGN;
         end
      end
   end

   assign code_enb     = code_enb_q;
   assign code_rst     = code_rst_q;
   assign nav_ready    = nav_ready_q;
   assign spread_out   = spread_out_q;
   assign spread_valid = spread_valid_q;
   assign chip_idx     = chip_idx_q;
   assign epoch        = epoch_q;
   assign bit_epoch    = bit_epoch_q;
   assign underrun     = underrun_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ca_chip_sequencer.sv
// Directed bench for ca_chip_sequencer, with a behavioural PRN1 C/A generator
// (registered chip output) closing the loop on code_rst/code_enb/chip_in.
module tb_ca_chip_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] clks_per_chip = '0;
   logic        chip_in;
   logic        code_enb;
   logic        code_rst;
   logic        nav_valid = 1'b0;
   logic        nav_bit = 1'b0;
   logic        nav_ready;
   logic        spread_out;
   logic        spread_valid;
   logic [9:0]  chip_idx;
   logic        epoch;
   logic        bit_epoch;
   logic        underrun;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int k = 0;

   logic [10:1] g1 = '1;
   logic [10:1] g2 = '1;
   logic        gen_chip = 1'b0;
   logic        ref_chip [1023];

   assign chip_in = gen_chip;

   always #5 clk = ~clk;

   ca_chip_sequencer #(
      .EPOCHS_PER_BIT (2),
      .CHIPS_PER_EPOCH(1023),
      .DIV_W          (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .clks_per_chip(clks_per_chip),
      .chip_in      (chip_in),
      .code_enb     (code_enb),
      .code_rst     (code_rst),
      .nav_valid    (nav_valid),
      .nav_bit      (nav_bit),
      .nav_ready    (nav_ready),
      .spread_out   (spread_out),
      .spread_valid (spread_valid),
      .chip_idx     (chip_idx),
      .epoch        (epoch),
      .bit_epoch    (bit_epoch),
      .underrun     (underrun),
      .busy         (busy)
   );

   // PRN1 generator model: LFSRs reset/advance on the edge, chip_out registered.
   always @(posedge clk) begin
      if (code_rst) begin
         g1 <= '1;
         g2 <= '1;
      end else if (code_enb) begin
         g1 <= {g1[9:1], g1[3] ^ g1[10]};
         g2 <= {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
      end
      gen_chip <= g1[10] ^ g2[2] ^ g2[6];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int tgt);
      while (k < tgt) tick;
   endtask

   task automatic do_start(input logic [15:0] c);
      clks_per_chip = c;
      start = 1'b1;
      tick;
      start = 1'b0;
      k = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [10:1] ra;
      logic [10:1] rb;
      logic [9:0]  got10;
      int          bad;
      int          ep_bad;
      int          nr_bad;
      int          n;
      int          first_k;
      int          second_k;
      logic        found;

      ra = '1;
      rb = '1;
      for (int i = 0; i < 1023; i++) begin
         ref_chip[i] = ra[10] ^ rb[2] ^ rb[6];
         ra = {ra[9:1], ra[3] ^ ra[10]};
         rb = {rb[9:1], rb[2] ^ rb[3] ^ rb[6] ^ rb[8] ^ rb[9] ^ rb[10]};
      end

      // Reset state
      repeat (3) tick;
      check("rst_strobes", {code_enb, code_rst, nav_ready, spread_valid, epoch, bit_epoch}, 0);
      check("rst_state", {spread_out, underrun, busy, chip_idx}, 0);
      rst = 1'b0;
      tick;

      // Basic timing, cpc=4
      nav_valid = 1'b1;
      nav_bit = 1'b0;
      do_start(16'd4);
      check("t1_code_rst_S1", code_rst, 1);
      check("t1_busy", busy, 1);
      bad = 0;
      n = 0;
      got10 = '0;
      while (k <= 50) begin
         if (code_enb !== (k >= 4 && k % 4 == 0)) bad++;
         if (code_rst !== (k == 1)) bad++;
         if (spread_valid !== (k >= 5 && (k - 5) % 4 == 0)) bad++;
         if (spread_valid && n < 10) begin
            got10[9-n] = spread_out;
            if (chip_idx != 10'(n)) bad++;
            n++;
         end
         if (k == 3) check("t1_nav_ready_A2", nav_ready, 1);
         tick;
      end
      check("t1_timing_pattern", bad, 0);
      check("t1_first10_chips", got10, 10'b1100100000);

      // Epoch and nav bit, cpc=3, EPOCHS_PER_BIT=2
      nav_bit = 1'b0;
      do_start(16'd3);
      bad = 0;
      ep_bad = 0;
      nr_bad = 0;
      n = 0;
      while (k <= 9215) begin
         if (k == 10) nav_bit = 1'b1;
         if (k >= 4 && spread_valid) begin
            if (chip_idx != 10'(n % 1023)) bad++;
            if (spread_out !== (ref_chip[n % 1023] ^ (n >= 2046))) bad++;
            n++;
         end
         if (epoch !== (k >= 3071 && (k - 3071) % 3069 == 0)) ep_bad++;
         if (bit_epoch !== (k == 6140)) ep_bad++;
         if (nav_ready !== (k == 3 || k == 6140)) nr_bad++;
         tick;
      end
      check("t2_spread_seq", bad, 0);
      check("t2_epoch_timing", ep_bad, 0);
      check("t2_nav_ready", nr_bad, 0);
      check("t2_sample_count", n, 3071);
      check("t2_no_underrun", underrun, 0);

      // Underrun at RUN entry
      stop = 1'b1;
      tick;
      stop = 1'b0;
      nav_valid = 1'b0;
      nav_bit = 1'b1;
      do_start(16'd3);
      run_to(4);
      check("t3_underrun_set", underrun, 1);
      run_to(5);
      check("t3_first_valid", spread_valid, 1);
      check("t3_cur_bit_zero", spread_out, 1);
      nav_valid = 1'b1;
      run_to(6143);
      check("t3_period2_valid", spread_valid, 1);
      check("t3_period2_bit1", spread_out, 0);
      check("t3_underrun_sticky", underrun, 1);
      do_start(16'd3);
      check("t3_underrun_cleared", underrun, 0);

      // Clamp of clks_per_chip 0 and 1
      for (int c = 0; c < 2; c++) begin
         stop = 1'b1;
         tick;
         stop = 1'b0;
         do_start(16'(c));
         first_k = -1;
         second_k = -1;
         while (k <= 20) begin
            if (code_enb) begin
               if (first_k < 0) first_k = k;
               else if (second_k < 0) second_k = k;
            end
            tick;
         end
         check("t4_first_enb", first_k, 4);
         check("t4_enb_period", second_k - first_k, 3);
      end

      // Stop at chip 500, then restart
      do_start(16'd3);
      nav_bit = 1'b0;
      found = 1'b0;
      while (!found && k < 4000) begin
         if (spread_valid && chip_idx == 10'd500) found = 1'b1;
         else tick;
      end
      check("t5_reach_chip500", found, 1);
      stop = 1'b1;
      tick;
      stop = 1'b0;
      check("t5_busy_low", busy, 0);
      check("t5_chip_idx_hold", chip_idx, 500);
      bad = 0;
      repeat (20) begin
         if (code_enb || spread_valid || nav_ready || code_rst) bad++;
         tick;
      end
      check("t5_quiet_after_stop", bad, 0);
      do_start(16'd3);
      check("t5_restart_code_rst", code_rst, 1);
      bad = 0;
      n = 0;
      got10 = '0;
      while (k <= 40) begin
         if (spread_valid && n < 10) begin
            got10[9-n] = spread_out;
            if (chip_idx != 10'(n)) bad++;
            n++;
         end
         tick;
      end
      check("t5_restart_idx", bad, 0);
      check("t5_restart_chips", got10, 10'b1100100000);

      // start and stop together while running
      start = 1'b1;
      stop = 1'b1;
      tick;
      start = 1'b0;
      stop = 1'b0;
      check("t5_start_stop_busy", busy, 0);
      check("t5_start_stop_no_rst", code_rst, 0);

      // Restart on a chip cycle keeps the in-flight sample
      do_start(16'd3);
      found = 1'b0;
      while (!found && k < 100) begin
         if (code_enb && k > 4) found = 1'b1;
         else tick;
      end
      check("t5_found_chip_cycle", found, 1);
      do_start(16'd3);
      check("t5_inflight_valid", spread_valid, 1);
      check("t5_inflight_code_rst", code_rst, 1);

      // Reset mid-run
      stop = 1'b1;
      tick;
      stop = 1'b0;
      nav_valid = 1'b0;
      do_start(16'd3);
      run_to(20);
      check("t6_pre_underrun", underrun, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("t6_rst_strobes", {code_enb, code_rst, nav_ready, spread_valid, epoch, bit_epoch}, 0);
      check("t6_rst_state", {spread_out, underrun, busy}, 0);
      check("t6_rst_chip_idx", chip_idx, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ca_chip_sequencer.md
Name: ca_chip_sequencer

Overview:
- Chip-timing and spreading stage that pairs with the C/A code generator (cacode).
- Sets the chip rate by driving the generator's enable and reset, and samples its chip output once per chip.
- Counts chips and code epochs (1023 chips), and pulls one navigation data bit per EPOCHS_PER_BIT epochs over a valid/ready handshake.
- Emits the spread chip (code chip XOR nav bit) with a valid strobe to the downstream modulator/correlator.

Parameters:
EPOCHS_PER_BIT, 20, code epochs per navigation bit (range 1..63)
CHIPS_PER_EPOCH, 1023, chips per code period
DIV_W, 16, width of clocks-per-chip divider

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; latch config and (re)start sequence
stop  in  1  pulse; halt and return to IDLE
clks_per_chip  in  DIV_W  clocks per chip; latched on accepted start
chip_in  in  1  chip from code generator (its registered chip_out)
code_enb  out  1  advance pulse to code generator
code_rst  out  1  reset pulse to code generator
nav_valid  in  1  nav bit available
nav_bit  in  1  nav data bit
nav_ready  out  1  nav bit consumed this cycle when nav_valid also high
spread_out  out  1  chip_in XOR current nav bit
spread_valid  out  1  one-cycle strobe, spread_out valid
chip_idx  out  10  index of chip most recently sampled, 0..CHIPS_PER_EPOCH-1
epoch  out  1  one-cycle pulse with spread_valid of final chip (idx 1022)
bit_epoch  out  1  one-cycle pulse with epoch when nav-bit period ends
underrun  out  1  sticky; a nav bit was needed while nav_valid low
busy  out  1  high in ALIGN and RUN

Behaviour:
- Reset: state IDLE. All outputs 0. Internal counters 0. Current nav bit 0.
- FSM states: IDLE, ALIGN, RUN.
- IDLE:
  - Accepted start: latch cpc = max(clks_per_chip, 3). Clear underrun. Go to ALIGN.
  - stop is ignored in IDLE.
- ALIGN, exactly 3 cycles (A0, A1, A2):
  - code_rst=1 in A0 only; code_enb=0 throughout.
  - Purpose: the generator's chip output lags its reset by 2 clocks.
  - After A2, go to RUN with div_cnt=0, chip_idx counter=0, epoch_cnt=0.
- Nav-bit load at RUN entry:
  - In A2, nav_ready=1. If nav_valid, cur_bit←nav_bit.
  - Else cur_bit←0 and underrun←1.
- RUN, chip divider:
  - div_cnt counts 0..cpc-1 and wraps.
  - On a div_cnt==0 cycle ("chip cycle"):
    - code_enb=1.
    - chip_in is sampled.
    - Next cycle: spread_out=chip_in^cur_bit, spread_valid=1, chip_idx=current chip count.
  - cpc≥3 guarantees chip_in is stable at the sample point (generator output settles 2 clocks after enb).
- RUN, chip counter:
  - Increments on each chip cycle and wraps at CHIPS_PER_EPOCH-1→0.
  - The sample of chip 1022 raises epoch together with its spread_valid.
  - epoch_cnt increments on epoch and wraps at EPOCHS_PER_BIT-1.
- RUN, nav-bit boundary:
  - On the chip cycle sampling chip 1022 with epoch_cnt==EPOCHS_PER_BIT-1: bit_epoch is raised with that epoch.
  - nav_ready=1 on the following cycle. cur_bit loads nav_bit if nav_valid; otherwise it loads 0 and sets underrun.
  - The new cur_bit applies from chip 0 of the next period. The cur_bit change never lands mid-chip-sample.
- nav_ready is a single-cycle pulse. Transfer occurs only when nav_valid && nav_ready.
- start during ALIGN/RUN: restart. Relatch cpc, clear underrun, re-enter ALIGN A0. Any in-flight spread_valid from the previous run still emits next cycle.
- stop during ALIGN/RUN: IDLE next cycle. code_enb/nav_ready/strobes are 0 from then on. spread_out and chip_idx hold last values.
- start and stop in the same cycle: stop wins.
- rst mid-operation: identical to power-on reset.
- busy=1 in ALIGN and RUN, 0 in IDLE.
- clks_per_chip changes while running have no effect until the next start.

Test Plan:
- Basic timing:
  - Stimulus: rst, then start at cycle S with clks_per_chip=4, nav_valid=1, nav_bit=0, generator prn_num=1.
  - Required: code_rst at S+1; first code_enb at S+4, then every 4 cycles.
  - spread_valid at S+5, S+9, … First 10 spread_out = 1,1,0,0,1,0,0,0,0,0 (PRN1 octal 1440).
- Epoch and nav bit, EPOCHS_PER_BIT=2, cpc=3:
  - Required: epoch every 3069 cycles. bit_epoch on the 2nd epoch. nav_ready pulse follows.
  - nav_bit=1 presented: the next period's spread_out is the inverse of the first period chip-for-chip.
- Underrun:
  - Stimulus: nav_valid=0 at RUN entry.
  - Required: underrun=1 and cur_bit=0. underrun stays 1 through later valid bits; cleared only by the next start.
- Clamp:
  - Stimulus: clks_per_chip=0 and then =1.
  - Required: code_enb period 3 cycles in both cases.
- Stop/restart:
  - Stimulus: stop at chip_idx=500 → busy=0 next cycle, no further code_enb. Then start.
  - Required: code_rst pulse, chip_idx restarts at 0, the PRN1 sequence restarts from 1,1,0,0….
  - start+stop in the same cycle while running → IDLE.
- Reset mid-RUN:
  - Stimulus: rst asserted.
  - Required: all outputs 0 next cycle, state IDLE, underrun cleared.
